// File: rtl/if_fetch_axi_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch unit and instruction memory.
// Ports (by modport):
//   master: drives arid/araddr/arlen/arsize/arburst/arvalid and rready;
//           receives arready and rid/rdata/rresp/rlast/rvalid.
//   slave:  the mirror image of master.
interface if_fetch_axi_if #(
  parameter int unsigned ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/if_fetch_axi.sv
// Instruction fetch unit: single-outstanding, single-beat AXI4 read master feeding the
// IF/ID pipeline register. Holds each fetched word until decode accepts it, and restarts
// the fetch stream on a redirect, discarding any beat already in flight.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_stall           decode not accepting the presented instruction this cycle
//   i_redirect(_pc)   one-cycle restart request and its target (low two bits ignored)
//   m_axi             AXI4 AR/R master channels
//   o_pc, o_inst      presented pc/instruction (zero when o_valid_inst is low)
//   o_valid_inst      presented pair is valid
//   o_bus_err         one-cycle pulse when an error-response instruction is first presented
module if_fetch_axi #(
  parameter logic [31:0]     RESET_PC = 32'h0000_0000,
  parameter int unsigned     ID_W     = 4,
  parameter logic [ID_W-1:0] AXI_ID   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  if_fetch_axi_if.master         m_axi,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_inst,
  output logic                   o_valid_inst,
  output logic                   o_bus_err
);

  typedef enum logic [1:0] {StAr, StR, StHold} state_e;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic        r_rready;
  logic        r_valid;
  logic [31:0] r_pc_out;
  logic [31:0] r_inst;
  logic        r_bus_err;

  logic [31:0] w_redir_pc;
  logic [31:0] w_next_pc;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_rsp_err;
  logic        w_unused_axi;

  assign w_redir_pc = {i_redirect_pc[31:2], 2'b00};
  // Redirect outranks sequential advance when leaving HOLD.
  assign w_next_pc  = i_redirect ? w_redir_pc : (r_pc + 32'd4);
  assign w_ar_hs    = r_arvalid & m_axi.arready;
  assign w_r_hs     = r_rready & m_axi.rvalid;
  assign w_rsp_err  = (m_axi.rresp != 2'b00);

  // Only one transaction is ever in flight and bursts are single-beat.
  assign w_unused_axi = ^{m_axi.rid, m_axi.rlast};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StAr;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_arvalid <= 1'b1;
      r_araddr  <= {RESET_PC[31:2], 2'b00};
      r_rready  <= 1'b0;
      r_valid   <= 1'b0;
      r_pc_out  <= 32'h0;
      r_inst    <= 32'h0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        StAr: begin
          // Address stays put until the handshake; the new pc is used on the next AR entry.
          if (i_redirect) begin
            r_pc   <= w_redir_pc;
            r_kill <= 1'b1;
          end
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (r_kill || i_redirect) begin
              // Stale beat: drop it and restart at the latest pc.
              r_kill    <= 1'b0;
              r_arvalid <= 1'b1;
              r_araddr  <= i_redirect ? w_redir_pc : r_pc;
              if (i_redirect) begin
                r_pc <= w_redir_pc;
              end
              r_state   <= StAr;
            end else begin
              r_valid   <= 1'b1;
              r_pc_out  <= r_pc;
              r_inst    <= w_rsp_err ? NopInst : m_axi.rdata;
              r_bus_err <= w_rsp_err;
              r_state   <= StHold;
            end
          end else if (i_redirect) begin
            r_pc   <= w_redir_pc;
            r_kill <= 1'b1;
          end
        end
        StHold: begin
          if (i_redirect || !i_stall) begin
            r_pc      <= w_next_pc;
            r_araddr  <= w_next_pc;
            r_arvalid <= 1'b1;
            r_valid   <= 1'b0;
            r_pc_out  <= 32'h0;
            r_inst    <= 32'h0;
            r_state   <= StAr;
          end
        end
        default: r_state <= StAr;
      endcase
    end
  end

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign o_pc         = r_pc_out;
  assign o_inst       = r_inst;
  assign o_valid_inst = r_valid;
  assign o_bus_err    = r_bus_err;

endmodule

// File: doc/if_fetch_axi.md
Name: if_fetch_axi

Overview:
- Instruction fetch unit: AXI4 read-only master toward instruction memory.
- Produces the pc/instruction/valid triple consumed by the IF/ID pipeline register, honouring the pipeline stall and branch/jump redirects.
- Single outstanding transaction, single-beat bursts.
- Keeps each fetched instruction until the decode side accepts it.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
ID_W, 4, width of AXI ARID/RID
AXI_ID, 0, constant ARID value driven on every request

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_stall  input  1  pipeline stall; instruction not accepted this cycle
i_redirect  input  1  one-cycle pulse: discard fetch stream, restart at i_redirect_pc
i_redirect_pc  input  32  redirect target
o_arid  output  ID_W  constant AXI_ID
o_araddr  output  32  fetch address, bits[1:0] always 0
o_arlen  output  8  constant 0
o_arsize  output  3  constant 3'b010
o_arburst  output  2  constant 2'b01 (INCR)
o_arvalid  output  1  read address valid
i_arready  input  1  read address ready
i_rid  input  ID_W  ignored (single outstanding)
i_rdata  input  32  read data
i_rresp  input  2  read response
i_rlast  input  1  ignored (ARLEN=0)
i_rvalid  input  1  read data valid
o_rready  output  1  read data ready
o_pc  output  32  pc of presented instruction
o_inst  output  32  presented instruction
o_valid_inst  output  1  o_pc/o_inst valid
o_bus_err  output  1  one-cycle pulse: error response on a non-killed fetch

Behaviour:
- Reset values:
  - State AR; pc=RESET_PC; kill=0; o_arvalid=1 immediately after reset release.
  - o_araddr=RESET_PC; o_rready=0; o_valid_inst=0; o_pc=0; o_inst=0; o_bus_err=0.
- Registers: pc[31:0], kill flag, inst buffer, state.
- States:
  - AR: o_arvalid=1, o_araddr={pc[31:2],2'b00}. On i_arready -> R.
  - R: o_rready=1. On i_rvalid:
    - kill=1 -> data discarded, kill cleared, -> AR.
    - Otherwise buffer captured -> HOLD.
  - HOLD: o_valid_inst=1, o_pc=pc, o_inst=buffer.
    - Consumption = o_valid_inst && !i_stall.
    - On consumption: pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000) -> AR.
    - While stalled: outputs held unchanged.
- o_pc/o_inst driven 0 whenever o_valid_inst=0.
- Latency: R handshake in cycle N -> o_valid_inst=1 in N+1. Consumption in cycle M -> o_arvalid=1 in M+1 at pc+4.
- Minimum 3 cycles per instruction (arready=1, rvalid one cycle after AR handshake).
- AXI rules:
  - While o_arvalid=1 without handshake, o_araddr must not change, including across a redirect.
  - At most one transaction in flight.
- Error responses:
  - i_rresp!=2'b00 on a non-killed beat -> buffer loaded with 32'h0000_0013 (NOP), delivered normally.
  - o_bus_err pulses in the same cycle o_valid_inst first rises.
  - Killed beats never raise o_bus_err.
- Redirect; pc<=i_redirect_pc&~3 in all cases:
  - HOLD: held instruction dropped, o_valid_inst=0 next cycle -> AR. Redirect outranks consumption in the same cycle.
  - AR with no handshake this cycle: kill=1, address unchanged, stay AR.
  - AR with handshake this cycle: kill=1 -> R.
  - R with no rvalid: kill=1.
  - R with rvalid in the same cycle: beat discarded, kill=0 -> AR at the new pc.
  - Repeated redirects while kill pending: latest target wins.
  - Kill flag gates capture only; the new pc drives o_araddr from the next AR entry.
- i_stall has no effect outside HOLD; fetch continues while stalled.
- Asynchronous reset mid-transaction returns to the reset state. The interconnect is reset by the same rst.

Test Plan:
- Reset release, arready=1, memory returns word at 0x0 one cycle after AR:
  - o_araddr=0x0, then 0x4, 0x8.
  - o_valid_inst rises 2 cycles after each AR handshake.
  - o_pc sequence 0,4,8 with matching o_inst.
- Hold i_stall=1 for 5 cycles while o_valid_inst=1 (pc=0x4, inst=0x00500093):
  - o_pc/o_inst/o_valid_inst stable.
  - o_arvalid=0 throughout.
  - Release -> o_arvalid at 0x8 next cycle.
- i_arready held 0 for 3 cycles, i_redirect to 0x100 in the 2nd cycle:
  - o_araddr stays at the old pc until handshake.
  - Returned beat discarded, o_valid_inst stays 0.
  - Next AR address 0x100.
- i_redirect to 0x203 (pc 0x200 after masking) in the same cycle as i_rvalid:
  - No instruction presented.
  - Next o_araddr=0x200; then o_pc=0x200.
- i_rresp=2'b10 on fetch at 0x40:
  - o_inst=0x00000013, o_pc=0x40, o_bus_err high exactly one cycle.
  - Same error on a killed beat -> no o_bus_err.
- Redirect to 0xFFFF_FFFC, consume:
  - Next o_araddr=0x0000_0000 (wrap).
  - Async rst asserted mid R-wait -> all outputs at reset values without a clock edge.
